// File: rtl/adc_sample_avg.sv
`timescale 1ns/1ps
// adc_sample_avg: captures AD7324 reader frames, acknowledges them on HOLD, and emits raw samples plus per-channel block averages.
// Build macro ADC_FORMAT_CHECK_EN: words with bit 15 set are acknowledged but dropped and counted in ERR_COUNT.
module adc_sample_avg #(
    parameter int unsigned SKIP_FRAMES = 3,
    parameter int unsigned MIN_LOW     = 12,
    parameter int unsigned AVG_LOG2    = 3
) (
    input  logic        CLK_IN,
    input  logic        R,
    input  logic        CS,
    input  logic [15:0] DATA_READ,
    output logic        HOLD,
    output logic [15:0] RAW_DATA,
    output logic [1:0]  RAW_CH,
    output logic        RAW_VALID,
    output logic [15:0] AVG_DATA,
    output logic [1:0]  AVG_CH,
    output logic        AVG_VALID,
    output logic [7:0]  ERR_COUNT
);
    localparam int unsigned LOW_W  = 5;
    localparam int unsigned SKIP_W = (SKIP_FRAMES > 0) ? $clog2(SKIP_FRAMES + 1) : 1;
    localparam int unsigned ACC_W  = 13 + AVG_LOG2;
    localparam int unsigned CNT_W  = AVG_LOG2 + 1;

    localparam logic [LOW_W-1:0]  LOW_MAX  = '1;
    localparam logic [LOW_W-1:0]  LOW_ONE  = LOW_W'(1);
    localparam logic [LOW_W-1:0]  LOW_MIN  = LOW_W'(MIN_LOW);
    localparam logic [SKIP_W-1:0] SKIP_LIM = SKIP_W'(SKIP_FRAMES);
    localparam logic [SKIP_W-1:0] SKIP_ONE = SKIP_W'(1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'((32'd1 << AVG_LOG2) - 32'd1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOW    = 3'd1,
        SETTLE = 3'd2,
        ACK    = 3'd3,
        ACCUM  = 3'd4
    } state_t;

    state_t                   state;
    logic [LOW_W-1:0]         low_cnt;
    logic [SKIP_W-1:0]        skipped;
    logic [15:0]              sample;
    logic signed [ACC_W-1:0]  acc [4];
    logic [CNT_W-1:0]         cnt [4];

    // Decode of the captured word; sample stays stable through ACK and ACCUM.
    logic [1:0]              ch_c;
    logic signed [12:0]      smp_c;
    logic signed [ACC_W-1:0] sum_c;
    logic signed [ACC_W-1:0] avg_full_c;
    logic [15:0]             raw_c;
    logic [15:0]             avg_c;
    logic                    word_ok_c;

    assign ch_c       = sample[14:13];
    assign smp_c      = sample[12:0];
    assign sum_c      = acc[ch_c] + ACC_W'(smp_c);
    assign avg_full_c = sum_c >>> AVG_LOG2;
    assign raw_c      = {{3{sample[12]}}, sample[12:0]};
    assign avg_c      = {{3{avg_full_c[12]}}, avg_full_c[12:0]};

`ifdef ADC_FORMAT_CHECK_EN
    assign word_ok_c = ~sample[15];
`else
    logic unused_bit15_c;
    assign word_ok_c      = 1'b1;
    assign unused_bit15_c = sample[15];
    assign ERR_COUNT      = 8'd0;
`endif

    // Frame qualification, capture handshake and averaging sequencer.
    always_ff @(posedge CLK_IN) begin
        if (!R) begin
            state     <= IDLE;
            low_cnt   <= '0;
            skipped   <= '0;
            sample    <= '0;
            HOLD      <= 1'b0;
            RAW_DATA  <= '0;
            RAW_CH    <= '0;
            RAW_VALID <= 1'b0;
            AVG_DATA  <= '0;
            AVG_CH    <= '0;
            AVG_VALID <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                acc[i] <= '0;
                cnt[i] <= '0;
            end
`ifdef ADC_FORMAT_CHECK_EN
            ERR_COUNT <= '0;
`endif
        end else begin
            RAW_VALID <= 1'b0;
            AVG_VALID <= 1'b0;
            case (state)
                IDLE: begin
                    if (!CS) begin
                        low_cnt <= LOW_ONE;
                        state   <= LOW;
                    end
                end
                LOW: begin
                    if (!CS) begin
                        if (low_cnt != LOW_MAX) low_cnt <= low_cnt + LOW_ONE;
                    end else if (low_cnt < LOW_MIN) begin
                        state <= IDLE;
                    end else if (skipped < SKIP_LIM) begin
                        skipped <= skipped + SKIP_ONE;
                        state   <= IDLE;
                    end else begin
                        state <= SETTLE;
                    end
                end
                SETTLE: begin
                    sample <= DATA_READ;
                    HOLD   <= 1'b1;
                    state  <= ACK;
                end
                ACK: begin
                    HOLD <= 1'b0;
                    if (word_ok_c) begin
                        RAW_DATA  <= raw_c;
                        RAW_CH    <= ch_c;
                        RAW_VALID <= 1'b1;
                    end
`ifdef ADC_FORMAT_CHECK_EN
                    else if (ERR_COUNT != 8'hFF) ERR_COUNT <= ERR_COUNT + 8'd1;
`endif
                    state <= ACCUM;
                end
                ACCUM: begin
                    // Last sample of a block emits the mean and restarts that channel only.
                    if (word_ok_c) begin
                        if (cnt[ch_c] == CNT_LAST) begin
                            AVG_DATA   <= avg_c;
                            AVG_CH     <= ch_c;
                            AVG_VALID  <= 1'b1;
                            acc[ch_c]  <= '0;
                            cnt[ch_c]  <= '0;
                        end else begin
                            acc[ch_c]  <= sum_c;
                            cnt[ch_c]  <= cnt[ch_c] + CNT_ONE;
                        end
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
